lcd_spi_sink: RTL and testbench

Receive-side model of the LCD SPI link: samples `lcd_cs`/`lcd_dc`/`lcd_sclk`/`lcd_mosi` as driven by the LCD write path, reassembles 9-bit words (DC + byte), and decodes the ST7789-style command stream (CASET/RASET/RAMWR) into addressed RGB332 pixel writes. It sits on the bench side or in a loopback/capture path opposite the LCD transmitter. Its decoded pixel stream feeds a scoreboard or a shadow framebuffer.

---
 rtl/lcd_spi_sink.sv | 245 ++++++++++++++++++++++++
 tb/tb_lcd_spi_sink.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_sink.sv
// Receive side of the LCD SPI link: rebuilds 9-bit words and decodes CASET/RASET/RAMWR
// into addressed RGB332 pixel writes. Define LCD_SPI_SINK_STATS_EN to add pixel/error counters.
module lcd_spi_sink #(
  parameter int H_RES = 240,
  parameter int V_RES = 160
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        lcd_cs,
  input  logic        lcd_dc,
  input  logic        lcd_sclk,
  input  logic        lcd_mosi,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [7:0]  pix_data,
  output logic        frame_done,
  output logic        proto_err
`ifdef LCD_SPI_SINK_STATS_EN
  ,
  output logic [17:0] pix_count,
  output logic [7:0]  err_count
`endif
);

  localparam logic [8:0] XE_RST = 9'(H_RES - 1);
  localparam logic [8:0] YE_RST = 9'(V_RES - 1);

  typedef enum logic [2:0] {S_CMD, S_CASET, S_RASET, S_RAMWR, S_SKIP} state_t;

  logic [3:0] meta_r, sync_r;   // {cs, dc, sclk, mosi}
  logic       sclk_d_r;
  logic       cs_s, dc_s, mosi_s, sclk_rise_s, cs_err_s;
  logic [6:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       byte_valid_r, byte_dc_r;
  logic [7:0] byte_data_r;

  state_t     state_r, state_n;
  logic [2:0] pidx_r;
  logic       p0_r, p2_r;       // only bit 0 of the high parameter bytes is meaningful
  logic [7:0] p1_r;
  logic [8:0] xs_r, xe_r, ys_r, ye_r, cx_r, cy_r;
  logic       cmd_s, ramwr_s, param_s, commit_s, reject_s, pix_s;
  logic [8:0] new_start_s, new_end_s;

  logic       pix_valid_r, frame_done_r, proto_err_r;
  logic [8:0] pix_x_r, pix_y_r;
  logic [7:0] pix_data_r;

  assign cs_s        = sync_r[3];
  assign dc_s        = sync_r[2];
  assign mosi_s      = sync_r[0];
  assign sclk_rise_s = sync_r[1] & ~sclk_d_r;
  assign cs_err_s    = cs_s & (bit_cnt_r != 3'd0);

  // Two-flop synchronizers plus sclk history for edge detection; cs idles deselected
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= 4'b1000;
      sync_r   <= 4'b1000;
      sclk_d_r <= 1'b0;
    end else begin
      meta_r   <= {lcd_cs, lcd_dc, lcd_sclk, lcd_mosi};
      sync_r   <= meta_r;
      sclk_d_r <= sync_r[1];
    end
  end

  // Bit shifter and byte assembly
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      shift_r      <= 7'd0;
      bit_cnt_r    <= 3'd0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'd0;
      byte_dc_r    <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      if (cs_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        shift_r   <= {shift_r[5:0], mosi_s};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_valid_r <= 1'b1;
          byte_data_r  <= {shift_r, mosi_s};
          byte_dc_r    <= dc_s;
        end
      end
    end
  end

  // Decoder next state and per-byte actions
  always_comb begin
    state_n     = state_r;
    cmd_s       = 1'b0;
    ramwr_s     = 1'b0;
    param_s     = 1'b0;
    commit_s    = 1'b0;
    reject_s    = 1'b0;
    pix_s       = 1'b0;
    new_start_s = {p0_r, p1_r};
    new_end_s   = {p2_r, byte_data_r};
    if (byte_valid_r) begin
      if (!byte_dc_r) begin
        cmd_s = 1'b1;
        case (byte_data_r)
          8'h2A:   state_n = S_CASET;
          8'h2B:   state_n = S_RASET;
          8'h2C: begin
            state_n = S_RAMWR;
            ramwr_s = 1'b1;
          end
          default: state_n = S_SKIP;
        endcase
      end else begin
        case (state_r)
          S_CASET, S_RASET: begin
            if (!pidx_r[2]) begin
              param_s = 1'b1;
              if (pidx_r == 3'd3) begin
                if (new_start_s > new_end_s) begin
                  reject_s = 1'b1;
                end else begin
                  commit_s = 1'b1;
                end
              end else begin
                commit_s = 1'b0;
              end
            end else begin
              param_s = 1'b0;
            end
          end
          S_RAMWR: pix_s   = 1'b1;
          default: state_n = state_r;
        endcase
      end
    end else begin
      state_n = state_r;
    end
  end

  // Decoder state register
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_CMD;
    end else begin
      state_r <= state_n;
    end
  end

  // Parameter capture, window, cursor and pixel outputs
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pidx_r       <= 3'd0;
      p0_r         <= 1'b0;
      p1_r         <= 8'd0;
      p2_r         <= 1'b0;
      xs_r         <= 9'd0;
      xe_r         <= XE_RST;
      ys_r         <= 9'd0;
      ye_r         <= YE_RST;
      cx_r         <= 9'd0;
      cy_r         <= 9'd0;
      pix_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      proto_err_r  <= 1'b0;
      pix_x_r      <= 9'd0;
      pix_y_r      <= 9'd0;
      pix_data_r   <= 8'd0;
    end else begin
      pix_valid_r  <= pix_s;
      frame_done_r <= pix_s & (cx_r == xe_r) & (cy_r == ye_r);
      proto_err_r  <= cs_err_s | reject_s;
      if (cmd_s) begin
        pidx_r <= 3'd0;
      end else if (param_s) begin
        pidx_r <= pidx_r + 3'd1;
        case (pidx_r[1:0])
          2'd0:    p0_r <= byte_data_r[0];
          2'd1:    p1_r <= byte_data_r;
          2'd2:    p2_r <= byte_data_r[0];
          default: p0_r <= p0_r;
        endcase
      end
      if (commit_s) begin
        if (state_r == S_CASET) begin
          xs_r <= new_start_s;
          xe_r <= new_end_s;
        end else begin
          ys_r <= new_start_s;
          ye_r <= new_end_s;
        end
      end
      if (ramwr_s) begin
        cx_r <= xs_r;
        cy_r <= ys_r;
      end else if (pix_s) begin
        pix_x_r    <= cx_r;
        pix_y_r    <= cy_r;
        pix_data_r <= byte_data_r;
        if (cx_r == xe_r) begin
          cx_r <= xs_r;
          cy_r <= (cy_r == ye_r) ? ys_r : cy_r + 9'd1;
        end else begin
          cx_r <= cx_r + 9'd1;
        end
      end
    end
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign byte_dc    = byte_dc_r;
  assign pix_valid  = pix_valid_r;
  assign pix_x      = pix_x_r;
  assign pix_y      = pix_y_r;
  assign pix_data   = pix_data_r;
  assign frame_done = frame_done_r;
  assign proto_err  = proto_err_r;

`ifdef LCD_SPI_SINK_STATS_EN
  logic [17:0] pix_cnt_r;
  logic [7:0]  err_cnt_r;

  // Saturating activity counters
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_r <= 18'd0;
      err_cnt_r <= 8'd0;
    end else begin
      if (pix_valid_r && (pix_cnt_r != 18'h3FFFF)) pix_cnt_r <= pix_cnt_r + 18'd1;
      if (proto_err_r && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign pix_count = pix_cnt_r;
  assign err_count = err_cnt_r;
`endif

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Bench for lcd_spi_sink: drives SPI bytes and compares decoded bytes, pixels and errors
// against a window/pixel-index reference model.
module tb_lcd_spi_sink;
  localparam int HR = 16;
  localparam int VR = 8;

  logic clk_25MHz = 1'b0;
  logic rst_n = 1'b0, lcd_cs = 1'b1, lcd_dc = 1'b0, lcd_sclk = 1'b0, lcd_mosi = 1'b0;
  logic       byte_valid, byte_dc, pix_valid, frame_done, proto_err;
  logic [7:0] byte_data, pix_data;
  logic [8:0] pix_x, pix_y;
  logic [38:0] outs;

  lcd_spi_sink #(.H_RES(HR), .V_RES(VR)) dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .lcd_cs(lcd_cs), .lcd_dc(lcd_dc),
    .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_dc(byte_dc), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_data(pix_data), .frame_done(frame_done), .proto_err(proto_err));

  assign outs = {byte_valid, byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_data,
                 frame_done, proto_err};

  always #20 clk_25MHz = ~clk_25MHz;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  // Observation side (written only by the monitor)
  logic [8:0]  obs_bytes[$];
  logic [26:0] obs_pix[$];
  int obs_err = 0, stray_fd = 0, last_bv_cyc = 0;

  always @(negedge clk_25MHz) begin
    if (rst_n) begin
      if (byte_valid) begin
        obs_bytes.push_back({byte_dc, byte_data});
        last_bv_cyc = cyc;
      end
      if (pix_valid) obs_pix.push_back({frame_done, pix_x, pix_y, pix_data});
      else if (frame_done) stray_fd++;
      if (proto_err) obs_err++;
    end
  end

  // Expectation side and read pointers (written only from the initial block)
  logic [8:0]  exp_bytes[$];
  logic [26:0] exp_pix[$];
  int exp_err = 0, br = 0, pr = 0, er = 0;
  int half = 3, rise_cyc = 0;

  int m_state, m_pi, m_xs, m_xe, m_ys, m_ye, m_k;
  logic [7:0] m_prm[4];

  task automatic mdl_reset();
    m_state = 0; m_pi = 0; m_k = 0;
    m_xs = 0; m_xe = HR - 1; m_ys = 0; m_ye = VR - 1;
  endtask

  // Pixel k of a RAMWR burst lands at row-major offset k (mod window area) inside the window
  task automatic mdl_byte(input logic dc, input logic [7:0] d);
    int s, e, w, h, x, y;
    logic fd;
    exp_bytes.push_back({dc, d});
    if (!dc) begin
      m_pi = 0;
      m_state = (d == 8'h2A) ? 1 : (d == 8'h2B) ? 2 : (d == 8'h2C) ? 3 : 4;
      if (m_state == 3) m_k = 0;
    end else if ((m_state == 1 || m_state == 2) && m_pi < 4) begin
      m_prm[m_pi] = d;
      m_pi++;
      if (m_pi == 4) begin
        s = (m_prm[0][0] ? 256 : 0) + int'(m_prm[1]);
        e = (m_prm[2][0] ? 256 : 0) + int'(m_prm[3]);
        if (s > e) exp_err++;
        else if (m_state == 1) begin m_xs = s; m_xe = e; end
        else begin m_ys = s; m_ye = e; end
      end
    end else if (m_state == 3) begin
      w = m_xe - m_xs + 1;
      h = m_ye - m_ys + 1;
      x = m_xs + m_k % w;
      y = m_ys + (m_k / w) % h;
      fd = ((m_k % (w * h)) == w * h - 1);
      exp_pix.push_back({fd, 9'(x), 9'(y), d});
      m_k++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_25MHz);
    #1;
  endtask

  task automatic cs_low();
    lcd_cs = 1'b0; tick(2);
  endtask

  task automatic cs_high();
    tick(2); lcd_cs = 1'b1; tick(6);
  endtask

  task automatic spi_bits(input logic dc, input logic [7:0] d, input int nbits);
    lcd_dc = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      lcd_mosi = d[i];
      tick(half);
      lcd_sclk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      tick(half);
      lcd_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] d);
    spi_bits(dc, d, 8);
    mdl_byte(dc, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lcd_cs = 1'b1; lcd_sclk = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    mdl_reset();
    exp_bytes.delete(); exp_pix.delete(); exp_err = 0;
    br = obs_bytes.size(); pr = obs_pix.size(); er = obs_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(2);
    vectors++;
    if (outs !== 39'd0) begin miscompares++; $display("FAIL reset_hold outs=%h want=0", outs); end
    do_reset();
    tick(4);
    vectors++;
    if (outs !== 39'd0) begin miscompares++; $display("FAIL reset_idle outs=%h want=0", outs); end
    vectors++;
    if (obs_err != er) begin miscompares++; $display("FAIL reset_err got=%0d want=%0d", obs_err - er, 0); end
  endtask

  task automatic test_full_frame();
    do_reset();
    half = 2;
    cs_low();
    spi_byte(1'b0, 8'h2C);
    for (int i = 0; i < HR * VR; i++) spi_byte(1'b1, 8'hFF);
    spi_byte(1'b1, 8'hA5);
    cs_high();
    vectors++;
    if (obs_pix.size() - pr != HR * VR + 1) begin
      miscompares++; $display("FAIL frame_count got=%0d want=%0d", obs_pix.size() - pr, HR * VR + 1);
    end else begin
      vectors++;
      if (obs_pix[pr + HR * VR - 1] !== {1'b1, 9'(HR - 1), 9'(VR - 1), 8'hFF}) begin
        miscompares++; $display("FAIL frame_last got=%h want=%h", obs_pix[pr + HR * VR - 1],
                                {1'b1, 9'(HR - 1), 9'(VR - 1), 8'hFF});
      end
      vectors++;
      if (obs_pix[pr + HR * VR] !== {1'b0, 9'd0, 9'd0, 8'hA5}) begin
        miscompares++; $display("FAIL frame_wrap got=%h want=%h", obs_pix[pr + HR * VR], {1'b0, 9'd0, 9'd0, 8'hA5});
      end
    end
    for (int i = 0; i < exp_pix.size() && pr + i < obs_pix.size(); i++) begin
      vectors++;
      if (obs_pix[pr + i] !== exp_pix[i]) begin
        miscompares++; $display("FAIL frame_pix[%0d] got=%h want=%h", i, obs_pix[pr + i], exp_pix[i]);
      end
    end
    vectors++;
    if (stray_fd != 0) begin miscompares++; $display("FAIL frame_stray_fd got=%0d want=0", stray_fd); end
    pr = obs_pix.size(); exp_pix.delete(); br = obs_bytes.size(); exp_bytes.delete();
  endtask

  task automatic test_window();
    logic [7:0] seq[11] = '{8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0C, 8'h2B, 8'h00, 8'h05, 8'h00, 8'h06, 8'h2C};
    half = 3;
    cs_low();
    for (int i = 0; i < 11; i++) spi_byte((i != 0 && i != 5 && i != 10), seq[i]);
    for (int i = 0; i < 6; i++) spi_byte(1'b1, 8'h11 + 8'(i));
    cs_high();
    vectors++;
    if (obs_pix.size() - pr != 6) begin
      miscompares++; $display("FAIL window_count got=%0d want=6", obs_pix.size() - pr);
    end else begin
      vectors++;
      if (obs_pix[pr] !== {1'b0, 9'd10, 9'd5, 8'h11}) begin
        miscompares++; $display("FAIL window_first got=%h want=%h", obs_pix[pr], {1'b0, 9'd10, 9'd5, 8'h11});
      end
      vectors++;
      if (obs_pix[pr + 5] !== {1'b1, 9'd12, 9'd6, 8'h16}) begin
        miscompares++; $display("FAIL window_last got=%h want=%h", obs_pix[pr + 5], {1'b1, 9'd12, 9'd6, 8'h16});
      end
    end
    for (int i = 0; i < exp_pix.size() && pr + i < obs_pix.size(); i++) begin
      vectors++;
      if (obs_pix[pr + i] !== exp_pix[i]) begin
        miscompares++; $display("FAIL window_pix[%0d] got=%h want=%h", i, obs_pix[pr + i], exp_pix[i]);
      end
    end
    vectors++;
    if (obs_err - er != exp_err) begin miscompares++; $display("FAIL window_err got=%0d want=%0d", obs_err - er, exp_err); end
    pr = obs_pix.size(); exp_pix.delete(); br = obs_bytes.size(); exp_bytes.delete();
    er = obs_err; exp_err = 0;
  endtask

  task automatic test_cs_abort();
    cs_low();
    spi_bits(1'b0, 8'h55, 5);
    cs_high();
    exp_err++;
    cs_low();
    spi_byte(1'b0, 8'h2C);
    tick(5);
    vectors++;
    if ((last_bv_cyc - rise_cyc) < 2 || (last_bv_cyc - rise_cyc) > 4) begin
      miscompares++; $display("FAIL abort_latency got=%0d want=3", last_bv_cyc - rise_cyc);
    end
    cs_high();
    vectors++;
    if (obs_bytes.size() - br != 1) begin
      miscompares++; $display("FAIL abort_bytes got=%0d want=1", obs_bytes.size() - br);
    end else begin
      vectors++;
      if (obs_bytes[br] !== 9'h02C) begin miscompares++; $display("FAIL abort_byte got=%h want=%h", obs_bytes[br], 9'h02C); end
    end
    vectors++;
    if (obs_err - er != exp_err) begin miscompares++; $display("FAIL abort_err got=%0d want=%0d", obs_err - er, exp_err); end
    vectors++;
    if (obs_pix.size() != pr) begin miscompares++; $display("FAIL abort_pix got=%0d want=0", obs_pix.size() - pr); end
    br = obs_bytes.size(); exp_bytes.delete(); er = obs_err; exp_err = 0;
  endtask

  task automatic test_bad_caset();
    logic [7:0] seq[5] = '{8'h2A, 8'h00, 8'h20, 8'h00, 8'h10};
    do_reset();
    cs_low();
    for (int i = 0; i < 5; i++) spi_byte(i != 0, seq[i]);
    spi_byte(1'b0, 8'h2C);
    for (int i = 0; i < HR + 2; i++) spi_byte(1'b1, 8'($urandom_range(255)));
    cs_high();
    vectors++;
    if (obs_err - er != 1) begin miscompares++; $display("FAIL badcaset_err got=%0d want=1", obs_err - er); end
    vectors++;
    if (obs_pix.size() - pr != exp_pix.size()) begin
      miscompares++; $display("FAIL badcaset_count got=%0d want=%0d", obs_pix.size() - pr, exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && pr + i < obs_pix.size(); i++) begin
      vectors++;
      if (obs_pix[pr + i] !== exp_pix[i]) begin
        miscompares++; $display("FAIL badcaset_pix[%0d] got=%h want=%h", i, obs_pix[pr + i], exp_pix[i]);
      end
    end
    pr = obs_pix.size(); exp_pix.delete(); br = obs_bytes.size(); exp_bytes.delete();
    er = obs_err; exp_err = 0;
  endtask

  task automatic test_unknown_cmd();
    cs_low();
    spi_byte(1'b0, 8'h36);
    spi_byte(1'b1, 8'h00);
    tick(6);
    vectors++;
    if (obs_pix.size() != pr) begin miscompares++; $display("FAIL unknown_pix got=%0d want=0", obs_pix.size() - pr); end
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'h5A);
    spi_byte(1'b1, 8'hC3);
    cs_high();
    vectors++;
    if (obs_bytes.size() - br != exp_bytes.size()) begin
      miscompares++; $display("FAIL unknown_bytes got=%0d want=%0d", obs_bytes.size() - br, exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size() && br + i < obs_bytes.size(); i++) begin
      vectors++;
      if (obs_bytes[br + i] !== exp_bytes[i]) begin
        miscompares++; $display("FAIL unknown_byte[%0d] got=%h want=%h", i, obs_bytes[br + i], exp_bytes[i]);
      end
    end
    vectors++;
    if (obs_pix.size() - pr != exp_pix.size()) begin
      miscompares++; $display("FAIL unknown_count got=%0d want=%0d", obs_pix.size() - pr, exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && pr + i < obs_pix.size(); i++) begin
      vectors++;
      if (obs_pix[pr + i] !== exp_pix[i]) begin
        miscompares++; $display("FAIL unknown_pix[%0d] got=%h want=%h", i, obs_pix[pr + i], exp_pix[i]);
      end
    end
    pr = obs_pix.size(); exp_pix.delete(); br = obs_bytes.size(); exp_bytes.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cs_low();
    spi_byte(1'b0, 8'h2C);
    for (int i = 0; i < 5 * HR + 10; i++) spi_byte(1'b1, 8'($urandom_range(255)));
    spi_bits(1'b1, 8'hF0, 4);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (outs !== 39'd0) begin miscompares++; $display("FAIL midreset_outs got=%h want=0", outs); end
    lcd_cs = 1'b1; lcd_sclk = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    vectors++;
    if (obs_pix.size() - pr != exp_pix.size()) begin
      miscompares++; $display("FAIL midreset_count got=%0d want=%0d", obs_pix.size() - pr, exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && pr + i < obs_pix.size(); i++) begin
      vectors++;
      if (obs_pix[pr + i] !== exp_pix[i]) begin
        miscompares++; $display("FAIL midreset_pix[%0d] got=%h want=%h", i, obs_pix[pr + i], exp_pix[i]);
      end
    end
    pr = obs_pix.size(); exp_pix.delete(); mdl_reset();
    cs_low();
    for (int i = 0; i < 3; i++) spi_byte(1'b1, 8'h40 + 8'(i));
    tick(6);
    vectors++;
    if (obs_pix.size() != pr) begin miscompares++; $display("FAIL midreset_nopix got=%0d want=0", obs_pix.size() - pr); end
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'h77);
    cs_high();
    vectors++;
    if (obs_pix.size() - pr != 1 || obs_pix[pr] !== {1'b0, 9'd0, 9'd0, 8'h77}) begin
      miscompares++; $display("FAIL midreset_after got=%h want=%h", (obs_pix.size() > pr) ? obs_pix[pr] : 27'h0,
                              {1'b0, 9'd0, 9'd0, 8'h77});
    end
    pr = obs_pix.size(); exp_pix.delete(); br = obs_bytes.size(); exp_bytes.delete();
    er = obs_err; exp_err = 0;
  endtask

  task automatic test_random();
    int s, e, n;
    for (int it = 0; it < 8; it++) begin
      half = int'($urandom_range(4, 2));
      cs_low();
      for (int c = 0; c < 2; c++) begin
        spi_byte(1'b0, (c == 0) ? 8'h2A : 8'h2B);
        s = int'($urandom_range((c == 0) ? HR - 1 : VR - 1));
        e = int'($urandom_range((c == 0) ? HR - 1 : VR - 1));
        if (it < 6 && s > e) begin n = s; s = e; e = n; end
        spi_byte(1'b1, {7'($urandom), 1'b0});
        spi_byte(1'b1, 8'(s));
        spi_byte(1'b1, {7'($urandom), 1'b0});
        spi_byte(1'b1, 8'(e));
        if ($urandom_range(1) == 1) spi_byte(1'b1, 8'($urandom));
      end
      if ($urandom_range(1) == 1) begin cs_high(); cs_low(); end
      spi_byte(1'b0, 8'h2C);
      n = int'($urandom_range(30, 1));
      for (int i = 0; i < n; i++) spi_byte(1'b1, 8'($urandom));
      cs_high();
    end
    vectors++;
    if (obs_bytes.size() - br != exp_bytes.size()) begin
      miscompares++; $display("FAIL random_bytes got=%0d want=%0d", obs_bytes.size() - br, exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size() && br + i < obs_bytes.size(); i++) begin
      vectors++;
      if (obs_bytes[br + i] !== exp_bytes[i]) begin
        miscompares++; $display("FAIL random_byte[%0d] got=%h want=%h", i, obs_bytes[br + i], exp_bytes[i]);
      end
    end
    vectors++;
    if (obs_pix.size() - pr != exp_pix.size()) begin
      miscompares++; $display("FAIL random_count got=%0d want=%0d", obs_pix.size() - pr, exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && pr + i < obs_pix.size(); i++) begin
      vectors++;
      if (obs_pix[pr + i] !== exp_pix[i]) begin
        miscompares++; $display("FAIL random_pix[%0d] got=%h want=%h", i, obs_pix[pr + i], exp_pix[i]);
      end
    end
    vectors++;
    if (obs_err - er != exp_err) begin miscompares++; $display("FAIL random_err got=%0d want=%0d", obs_err - er, exp_err); end
    vectors++;
    if (stray_fd != 0) begin miscompares++; $display("FAIL random_stray_fd got=%0d want=0", stray_fd); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_window();
    test_cs_abort();
    test_unknown_cmd();
    test_bad_caset();
    test_reset_mid();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
